ram_stream_reader: RTL and testbench

Read-side DMA engine for the team's two-port simulation RAMs with registered addresses (AAddrRd captured on AClkH, AMiso = Mem[captured address]). On a start command it walks a block of consecutive RAM addresses, accounts for the one-cycle address-register latency, buffers returned words in a 3-entry FIFO and presents them on a valid/ready stream. It sits between a RAM read port and any stream consumer (UART TX, scope dump, DMA out).

---
 rtl/ram_stream_reader_if.sv | 31 +++
 rtl/ram_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_ram_stream_reader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// RAM read port plus output stream bundle for ram_stream_reader.
interface ram_stream_reader_if #(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 16
);
  logic [CAddrLen-1:0] ARamAddrRd;
  logic [CDataLen-1:0] ARamMiso;
  logic [CDataLen-1:0] AStrmData;
  logic                AStrmVld;
  logic                AStrmRdy;

  // Stream handshake: a word moves on a rising AClkH edge with AClkHEn=1 when
  // AStrmVld and AStrmRdy are both high. Once AStrmVld rises, the master keeps
  // AStrmVld high and AStrmData unchanged until that transfer happens;
  // AStrmVld never depends on AStrmRdy.
  modport master (
    output ARamAddrRd,
    input  ARamMiso,
    output AStrmData,
    output AStrmVld,
    input  AStrmRdy
  );

  modport slave (
    input  ARamAddrRd,
    output ARamMiso,
    input  AStrmData,
    input  AStrmVld,
    output AStrmRdy
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Read-side DMA engine: walks a block of RAM addresses through a RAM with a
// registered read address, buffers returned words in a 3-entry FIFO and
// presents them on a valid/ready stream.
module ram_stream_reader #(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 16
) (
  input  logic                AClkH,
  input  logic                AResetB,
  input  logic                AClkHEn,
  input  logic                AStart,
  input  logic [CAddrLen-1:0] AStartAddr,
  input  logic [CAddrLen:0]   ALen,
  output logic                ABusy,
  output logic                ADone,
  output logic [1:0]          ADbgState,
  ram_stream_reader_if.master Bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CAddrLen-1:0] AddrOne = 1;
  localparam logic [CAddrLen:0]   LenOne  = 1;

  state_t              state_q;
  logic [CAddrLen-1:0] addr_q;
  logic [CAddrLen:0]   remain_q;
  logic                in_flight_q;
  logic                in_flight_d;
  logic                busy_q;
  logic                done_q;

  // FIFO storage and bookkeeping
  logic [CDataLen-1:0] mem_q [3];
  logic [1:0]          wr_ptr_q;
  logic [1:0]          wr_ptr_d;
  logic [1:0]          rd_ptr_q;
  logic [1:0]          rd_ptr_d;
  logic [1:0]          count_q;
  logic [1:0]          count_d;

  logic                vld;
  logic                push;
  logic                pop;
  logic                issue;
  logic [2:0]          occupancy;

  assign vld  = (count_q != 2'd0);
  assign pop  = vld & Bus.AStrmRdy;
  // The word for a read issued last enabled cycle is on ARamMiso now.
  assign push = in_flight_q;

  // Slots already spoken for: buffered words plus the one still in the RAM.
  assign occupancy = {1'b0, count_q} + {2'b00, in_flight_q};

  // Issue only if the returning word is guaranteed a free FIFO slot.
  assign issue       = (state_q == S_RUN) && (remain_q != '0) && (occupancy < 3'd3);
  assign in_flight_d = issue;

  assign Bus.ARamAddrRd = addr_q;
  assign Bus.AStrmVld   = vld;
  assign Bus.AStrmData  = vld ? mem_q[rd_ptr_q] : '0;

  assign ABusy     = busy_q;
  assign ADone     = done_q;
  assign ADbgState = state_q;

  // Next FIFO occupancy and pointer values (simultaneous push/pop keeps count)
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
  end

  // Control FSM: address walk, remaining count, in-flight flag, busy/done flags
  always_ff @(posedge AClkH or negedge AResetB) begin
    if (!AResetB) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      in_flight_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (AClkHEn) begin
      in_flight_q <= in_flight_d;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (AStart) begin
            addr_q   <= AStartAddr;
            remain_q <= ALen;
            busy_q   <= 1'b1;
            if (ALen == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            addr_q   <= addr_q + AddrOne;
            remain_q <= remain_q - LenOne;
            if (remain_q == LenOne) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Leave on the edge where the last word drains, so ADone follows
          // immediately in the next enabled cycle.
          if (!in_flight_d && (count_d == 2'd0)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO: capture returning RAM words, advance pointers and occupancy
  always_ff @(posedge AClkH or negedge AResetB) begin
    if (!AResetB) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
    end else if (AClkHEn) begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        mem_q[wr_ptr_q] <= Bus.ARamMiso;
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: registered-address RAM model, randomised
// back-pressure, clock-enable pattern and a word scoreboard.
module tb_ram_stream_reader;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          AClkH      = 1'b0;
  logic          AResetB    = 1'b0;
  logic          AClkHEn    = 1'b1;
  logic          AStart     = 1'b0;
  logic [AW-1:0] AStartAddr = '0;
  logic [AW:0]   ALen       = '0;
  logic          ABusy;
  logic          ADone;
  logic [1:0]    ADbgState;

  ram_stream_reader_if #(.CAddrLen(AW), .CDataLen(DW)) bus ();

  ram_stream_reader #(.CAddrLen(AW), .CDataLen(DW)) dut (
    .AClkH      (AClkH),
    .AResetB    (AResetB),
    .AClkHEn    (AClkHEn),
    .AStart     (AStart),
    .AStartAddr (AStartAddr),
    .ALen       (ALen),
    .ABusy      (ABusy),
    .ADone      (ADone),
    .ADbgState  (ADbgState),
    .Bus        (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 AClkH = ~AClkH;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model (registered read address, shared enable) ----
  logic [DW-1:0] ram [256];
  logic [AW-1:0] ram_addr_q = '0;
  always @(posedge AClkH) if (AClkHEn) ram_addr_q <= bus.ARamAddrRd;
  assign bus.ARamMiso = ram[ram_addr_q];

  // ---------------- stimulus drivers ----------------
  logic en_pat   = 1'b0;
  logic rdy_rand = 1'b0;
  int   en_phase = 0;

  // Enable pattern 1,0,0,1 and ready (70% high) applied just after each edge.
  always @(posedge AClkH) begin
    #1;
    if (en_pat) begin
      AClkHEn  = (en_phase == 0) || (en_phase == 3);
      en_phase = (en_phase + 1) % 4;
    end else begin
      AClkHEn = 1'b1;
    end
    if (rdy_rand) bus.AStrmRdy = ($urandom_range(0, 99) >= 30);
    else          bus.AStrmRdy = 1'b1;
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AClkH);
    #1;
  endtask

  task automatic start_xfer(input logic [AW-1:0] a, input logic [AW:0] n);
    logic [AW-1:0] wa;
    int k;
    for (int i = 0; i < int'(n); i++) begin
      wa = a + i[AW-1:0];
      exp_q.push_back(16'h0100 + {8'h00, wa});
    end
    AStartAddr = a;
    ALen       = n;
    AStart     = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!ABusy && k < 16);
    check("start_accepted", {31'd0, ABusy}, 32'd1);
    AStart = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (ABusy && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, {31'd0, ABusy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, ABusy}, 32'd0);
    check({tag, "_done"},  {31'd0, ADone}, 32'd0);
    check({tag, "_addr"},  {24'd0, bus.ARamAddrRd}, 32'd0);
    check({tag, "_vld"},   {31'd0, bus.AStrmVld}, 32'd0);
    check({tag, "_data"},  {16'd0, bus.AStrmData}, 32'd0);
    check({tag, "_state"}, {30'd0, ADbgState}, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int            word_cnt  = 0;
  int            done_cnt  = 0;
  logic          prev_hold = 1'b0;
  logic          prev_dis  = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [31:0]   snap      = '0;
  logic [31:0]   prev_snap = '0;
  logic [DW-1:0] exp_w;

  // Sample on the falling edge: transfers, stall stability, disabled-cycle hold.
  always @(negedge AClkH) begin
    if (!AResetB) begin
      prev_hold = 1'b0;
      prev_dis  = 1'b0;
    end else begin
      snap = {3'd0, ADbgState, ABusy, ADone, bus.AStrmVld, bus.AStrmData, bus.ARamAddrRd};
      if (prev_dis) check("hold_when_disabled", snap, prev_snap);
      if (prev_hold) begin
        check("stall_vld",  {31'd0, bus.AStrmVld}, 32'd1);
        check("stall_data", {16'd0, bus.AStrmData}, {16'd0, prev_data});
      end
      if (dut.in_flight_q) check("no_push_when_full", {31'd0, dut.count_q == 2'd3}, 32'd0);
      if (bus.AStrmVld && bus.AStrmRdy && AClkHEn) begin
        word_cnt++;
        check("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("stream_word", {16'd0, bus.AStrmData}, {16'd0, exp_w});
        end
      end
      if (ADone && AClkHEn) done_cnt++;
      prev_hold = bus.AStrmVld && !(bus.AStrmRdy && AClkHEn);
      prev_data = bus.AStrmData;
      prev_dis  = !AClkHEn;
      prev_snap = snap;
    end
  end

  // ---------------- directed sequence ----------------
  int d0;
  int w0;
  int n;

  initial begin
    bus.AStrmRdy = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0100 + i[15:0];

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    AResetB = 1'b1;
    tick();

    // Basic: 4 words from 0x10, cycle-exact valid/done/busy
    d0 = done_cnt;
    start_xfer(8'h10, 9'd4);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("basic_vld_c%0d", c),  {31'd0, bus.AStrmVld}, {31'd0, (c >= 3 && c <= 6)});
      check($sformatf("basic_done_c%0d", c), {31'd0, ADone}, {31'd0, (c == 7)});
      check($sformatf("basic_busy_c%0d", c), {31'd0, ABusy}, {31'd0, (c <= 7)});
      tick();
    end
    check("basic_all_words", exp_q.size(), 32'd0);
    check("basic_done_once", done_cnt - d0, 32'd1);

    // Back-pressure with a start attempt while busy
    d0 = done_cnt;
    rdy_rand = 1'b1;
    start_xfer(8'h40, 9'd8);
    tick();
    tick();
    AStartAddr = 8'h80;
    ALen       = 9'd5;
    AStart     = 1'b1;
    tick();
    tick();
    AStart = 1'b0;
    wait_idle("bp", 300);
    rdy_rand = 1'b0;
    tick();
    tick();
    check("bp_no_restart", {31'd0, ABusy}, 32'd0);
    check("bp_all_words", exp_q.size(), 32'd0);
    check("bp_done_once", done_cnt - d0, 32'd1);

    // Address wrap
    d0 = done_cnt;
    start_xfer(8'hFE, 9'd4);
    wait_idle("wrap", 50);
    check("wrap_all_words", exp_q.size(), 32'd0);
    check("wrap_done_once", done_cnt - d0, 32'd1);

    // Zero length
    d0 = done_cnt;
    w0 = word_cnt;
    start_xfer(8'h33, 9'd0);
    check("len0_done_c1", {31'd0, ADone}, 32'd1);
    check("len0_vld_c1",  {31'd0, bus.AStrmVld}, 32'd0);
    tick();
    check("len0_busy_c2", {31'd0, ABusy}, 32'd0);
    check("len0_vld_c2",  {31'd0, bus.AStrmVld}, 32'd0);
    check("len0_no_words", word_cnt - w0, 32'd0);
    check("len0_done_once", done_cnt - d0, 32'd1);

    // Full address space
    d0 = done_cnt;
    w0 = word_cnt;
    start_xfer(8'h80, 9'd256);
    wait_idle("full", 400);
    check("full_all_words", exp_q.size(), 32'd0);
    check("full_word_count", word_cnt - w0, 32'd256);
    check("full_done_once", done_cnt - d0, 32'd1);

    // Clock-enable pattern 1,0,0,1
    d0 = done_cnt;
    en_pat = 1'b1;
    start_xfer(8'h10, 9'd4);
    wait_idle("cen", 100);
    en_pat = 1'b0;
    tick();
    check("cen_all_words", exp_q.size(), 32'd0);
    check("cen_done_once", done_cnt - d0, 32'd1);

    // Reset after two words of a six-word transfer
    d0 = done_cnt;
    w0 = word_cnt;
    start_xfer(8'h20, 9'd6);
    n = 0;
    while (word_cnt < w0 + 2 && n < 50) begin
      tick();
      n++;
    end
    check("rst_two_words_seen", word_cnt - w0, 32'd2);
    AResetB = 1'b0;
    #1;
    check_reset_outputs("rst_immediate");
    exp_q.delete();
    tick();
    tick();
    check_reset_outputs("rst_held");
    AResetB = 1'b1;
    tick();
    check("rst_no_done", done_cnt - d0, 32'd0);
    w0 = word_cnt;
    start_xfer(8'h30, 9'd2);
    wait_idle("rst_restart", 50);
    check("rst_restart_words", word_cnt - w0, 32'd2);
    check("rst_restart_all", exp_q.size(), 32'd0);
    check("rst_restart_done", done_cnt - d0, 32'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
